regfile_writeback: RTL
======================

Name: regfile_writeback

Overview:
- Writeback stage directly downstream of the 8-bit ALU. Captures `alu_result` and the condition bit (`zero`/CB) into a one-entry writeback register, then commits to the architectural register file and CB flag on the following clock edge.
- Provides the two operand read ports (rs, rt) that feed the ALU.
- Read ports have full bypass from the pending writeback entry, so back-to-back dependent instructions need no stall.

Parameters:
- DATA_W, 8, register/datapath width.
- NUM_REGS, 8, number of architectural registers.
- ADDR_W, 3, register address width; must equal clog2(NUM_REGS).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- valid_i  in  1  ALU outputs are valid this cycle.
- stall_i  in  1  hold: do not capture a new entry.
- flush_i  in  1  squash: discard the incoming entry (taken branch).
- opcode_i  in  4  opcode of the instruction in the ALU.
- rd_addr_i  in  ADDR_W  destination register.
- alu_result_i  in  DATA_W  ALU result.
- zero_i  in  1  ALU condition bit.
- rs_addr_i  in  ADDR_W  read port A address.
- rt_addr_i  in  ADDR_W  read port B address; decode drives 7 for implicit $r7 operations.
- rs_data_o  out  DATA_W  read port A data, bypassed.
- rt_data_o  out  DATA_W  read port B data, bypassed.
- cb_o  out  1  current CB flag, bypassed.
- wb_valid_o  out  1  writeback entry pending this cycle.
- wb_addr_o  out  ADDR_W  pending destination.
- wb_data_o  out  DATA_W  pending data.

Behaviour:
- Reset (asynchronous, active-high): all registers 0, CB 0, stage invalid.
  - Outputs during reset: wb_valid_o=0, wb_addr_o=0, wb_data_o=0, cb_o=0, rs_data_o=0, rt_data_o=0.
- Opcode classes:
  - REG-WRITE: 0000 and, 0001 add, 0010 sll, 0011 srl, 0100 sub, 0110 abs, 1000 set, 1001 addc.
  - CB-WRITE: 0101 slt, 0111 seq. These update CB from zero_i and do not write a register.
  - NONE: 1010-1111. No architectural effect; entry is still captured, but with both write enables 0.
- Capture at each rising edge: stage_valid <= valid_i & ~stall_i & ~flush_i.
  - When capturing, latch opcode class, rd_addr_i, alu_result_i and zero_i.
  - Priority: flush_i > stall_i > valid_i. flush and valid in the same cycle leaves the stage empty.
- Commit at the same edge, using the old stage contents:
  - If stage_valid and REG-WRITE: rf[wb_addr] <= wb_data.
  - If stage_valid and CB-WRITE: cb_reg <= stage_zero.
  - Each entry commits exactly once. A stall does not re-commit, because the stage empties unless refilled.
- flush_i never cancels an entry already in the stage; it has passed the commit point.
- Latency: ALU output in cycle N becomes architecturally visible (rf/cb_reg) after the edge ending cycle N+1. Through bypass it is visible on the read ports during cycle N+1.
- Read ports (combinational):
  - rs_data_o = (stage_valid & REG-WRITE & wb_addr==rs_addr_i) ? wb_data : rf[rs_addr_i]. Same rule for rt.
  - Both ports may hit the bypass simultaneously; rs_addr_i==rt_addr_i is legal.
- cb_o = (stage_valid & CB-WRITE) ? stage_zero : cb_reg.
- wb_valid_o = stage_valid & REG-WRITE; wb_addr_o and wb_data_o reflect the stage contents.
- Reset asserted mid-operation: the pending entry is dropped with no commit; register contents return to 0.
- No hard-wired zero register; all NUM_REGS registers are writable.
- Width: no arithmetic in this block; data passes through at DATA_W unchanged.

Decomposition:
- Shared package (also used by the ALU and decode):
  - 4-bit opcode constants: OP_AND, OP_ADD, OP_SLL, OP_SRL, OP_SUB, OP_SLT, OP_ABS, OP_SEQ, OP_SET, OP_ADDC.
  - DATA_W/ADDR_W constants.
  - Functions op_writes_reg(opcode) and op_writes_cb(opcode).
- Sub-module regfile_array:
  - NUM_REGS x DATA_W storage, 2 asynchronous read ports, 1 synchronous write port, async reset to 0.
  - The bypass and stage logic stay in the top level.

Test Plan:
- Reset then read all 8 addresses -> every read returns 0x00; cb_o=0; wb_valid_o=0.
- add (0001), rd=3, result 0x2A, valid 1 cycle; next cycle rs_addr=3 -> rs_data_o=0x2A via bypass, wb_valid_o=1; cycle after -> still 0x2A from rf, wb_valid_o=0.
- slt (0101) with zero_i=1 -> cb_o=1 the next cycle, no register changes; then seq (0111) with zero_i=0 -> cb_o=0 the following cycle.
- set (1000) rd=5 result 0x1F with flush_i=1 in the same cycle -> wb_valid_o stays 0, r5 unchanged (0x00); then a second write to r5 with stall_i=1 -> not captured.
- Back-to-back writes to r2 (0x11 then 0x22) with rs_addr=rt_addr=2 -> both ports show 0x11, then 0x22; final rf[2]=0x22.
- Write 0x55 to r7, assert reset while the r7 entry is pending -> after reset r7 reads 0x00, cb_o=0, wb_valid_o=0.

Source files
------------

// File: rtl/regfile_writeback_pkg.sv
// Shared definitions for the ALU / decode / writeback slice.
//   - datapath and register-file geometry constants
//   - 4-bit opcode encodings
//   - writeback class of an opcode and helper functions deriving it
package regfile_writeback_pkg;

   localparam int unsigned DATA_W   = 8;
   localparam int unsigned NUM_REGS = 8;
   localparam int unsigned ADDR_W   = 3;

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_ADD  = 4'b0001;
   localparam logic [3:0] OP_SLL  = 4'b0010;
   localparam logic [3:0] OP_SRL  = 4'b0011;
   localparam logic [3:0] OP_SUB  = 4'b0100;
   localparam logic [3:0] OP_SLT  = 4'b0101;
   localparam logic [3:0] OP_ABS  = 4'b0110;
   localparam logic [3:0] OP_SEQ  = 4'b0111;
   localparam logic [3:0] OP_SET  = 4'b1000;
   localparam logic [3:0] OP_ADDC = 4'b1001;

   // What an instruction does at commit: nothing, write a register, or write CB.
   typedef enum logic [1:0] {
      WB_NONE = 2'd0,
      WB_REG  = 2'd1,
      WB_CB   = 2'd2
   } wb_class_e;

   function automatic logic op_writes_reg(input logic [3:0] opcode);
      case (opcode)
         OP_AND, OP_ADD, OP_SLL, OP_SRL,
         OP_SUB, OP_ABS, OP_SET, OP_ADDC: op_writes_reg = 1'b1;
         default:                         op_writes_reg = 1'b0;
      endcase
   endfunction

   function automatic logic op_writes_cb(input logic [3:0] opcode);
      case (opcode)
         OP_SLT, OP_SEQ: op_writes_cb = 1'b1;
         default:        op_writes_cb = 1'b0;
      endcase
   endfunction

   function automatic wb_class_e op_class(input logic [3:0] opcode);
      if (op_writes_reg(opcode)) begin
         op_class = WB_REG;
      end else if (op_writes_cb(opcode)) begin
         op_class = WB_CB;
      end else begin
         op_class = WB_NONE;
      end
   endfunction

endpackage

// File: rtl/regfile_writeback_regfile_array.sv
// Architectural register storage.
//   NUM_REGS x DATA_W registers, two asynchronous read ports, one
//   synchronous write port, asynchronous active-high reset to zero.
// Ports:
//   clk, reset          clock / async reset
//   we, waddr, wdata    write port (committed on rising edge)
//   raddr_a, rdata_a    read port A (combinational)
//   raddr_b, rdata_b    read port B (combinational)
module regfile_array
   import regfile_writeback_pkg::*;
#(
   parameter int unsigned DATA_W   = regfile_writeback_pkg::DATA_W,
   parameter int unsigned NUM_REGS = regfile_writeback_pkg::NUM_REGS,
   parameter int unsigned ADDR_W   = regfile_writeback_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr_a,
   output logic [DATA_W-1:0] rdata_a,
   input  logic [ADDR_W-1:0] raddr_b,
   output logic [DATA_W-1:0] rdata_b
);

   logic [DATA_W-1:0] mem [NUM_REGS];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata_a = mem[raddr_a];
   assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/regfile_writeback.sv
// Writeback stage downstream of the 8-bit ALU.
//   Captures ALU output into a one-entry writeback register, commits it to
//   the register file / CB flag on the following edge, and serves the two
//   ALU operand read ports with full bypass from the pending entry.
// Ports:
//   clk, reset                  clock / async active-high reset
//   valid_i, stall_i, flush_i   capture control (flush > stall > valid)
//   opcode_i, rd_addr_i,
//   alu_result_i, zero_i        ALU outputs for the instruction in flight
//   rs_addr_i / rs_data_o       operand port A (bypassed)
//   rt_addr_i / rt_data_o       operand port B (bypassed)
//   cb_o                        current CB flag (bypassed)
//   wb_valid_o, wb_addr_o,
//   wb_data_o                   pending register write
module regfile_writeback
   import regfile_writeback_pkg::*;
#(
   parameter int unsigned DATA_W   = regfile_writeback_pkg::DATA_W,
   parameter int unsigned NUM_REGS = regfile_writeback_pkg::NUM_REGS,
   parameter int unsigned ADDR_W   = regfile_writeback_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              valid_i,
   input  logic              stall_i,
   input  logic              flush_i,
   input  logic [3:0]        opcode_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   input  logic [DATA_W-1:0] alu_result_i,
   input  logic              zero_i,
   input  logic [ADDR_W-1:0] rs_addr_i,
   input  logic [ADDR_W-1:0] rt_addr_i,
   output logic [DATA_W-1:0] rs_data_o,
   output logic [DATA_W-1:0] rt_data_o,
   output logic              cb_o,
   output logic              wb_valid_o,
   output logic [ADDR_W-1:0] wb_addr_o,
   output logic [DATA_W-1:0] wb_data_o
);

   logic              stage_valid;
   wb_class_e         stage_class;
   logic [ADDR_W-1:0] wb_addr;
   logic [DATA_W-1:0] wb_data;
   logic              stage_zero;
   logic              cb_reg;

   logic              capture;
   logic              reg_pending;
   logic              cb_pending;
   logic [DATA_W-1:0] rf_rs_data;
   logic [DATA_W-1:0] rf_rt_data;

   assign capture     = valid_i & ~stall_i & ~flush_i;
   assign reg_pending = stage_valid & (stage_class == WB_REG);
   assign cb_pending  = stage_valid & (stage_class == WB_CB);

   // Commit of the old entry and capture of the new one share one edge; the
   // stage empties whenever nothing is captured, so no entry commits twice.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stage_valid <= 1'b0;
         stage_class <= WB_NONE;
         wb_addr     <= '0;
         wb_data     <= '0;
         stage_zero  <= 1'b0;
         cb_reg      <= 1'b0;
      end else begin
         if (cb_pending) begin
            cb_reg <= stage_zero;
         end
         stage_valid <= capture;
         if (capture) begin
            stage_class <= op_class(opcode_i);
            wb_addr     <= rd_addr_i;
            wb_data     <= alu_result_i;
            stage_zero  <= zero_i;
         end
      end
   end

   regfile_array #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS),
      .ADDR_W   (ADDR_W)
   ) u_regfile_array (
      .clk     (clk),
      .reset   (reset),
      .we      (reg_pending),
      .waddr   (wb_addr),
      .wdata   (wb_data),
      .raddr_a (rs_addr_i),
      .rdata_a (rf_rs_data),
      .raddr_b (rt_addr_i),
      .rdata_b (rf_rt_data)
   );

   always_comb begin
      rs_data_o = rf_rs_data;
      rt_data_o = rf_rt_data;
      cb_o      = cb_reg;
      if (reg_pending && (wb_addr == rs_addr_i)) begin
         rs_data_o = wb_data;
      end
      if (reg_pending && (wb_addr == rt_addr_i)) begin
         rt_data_o = wb_data;
      end
      if (cb_pending) begin
         cb_o = stage_zero;
      end
   end

   assign wb_valid_o = reg_pending;
   assign wb_addr_o  = wb_addr;
   assign wb_data_o  = wb_data;

endmodule
